cdb_arbiter: RTL and testbench

//  Shares the PIPE_WIDTH common data buses (CDBs) among all functional-unit writeback sources (ALU0/1, BRU, LSU, MDU).

---
 rtl/cdb_arbiter_pkg.sv | 34 +++
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter_age_select.sv | 38 +++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared micro-architecture types for the writeback / CDB path:
// ROB tag width, pipe width, the writeback packet and the source list.
package cdb_arbiter_pkg;

    localparam int PIPE_WIDTH  = 2;
    localparam int TAG_WIDTH   = 4;
    localparam int ROB_ENTRIES = 1 << TAG_WIDTH;
    localparam int XLEN        = 32;
    localparam int NUM_WB_SRC  = 5;

    typedef enum logic [2:0] {
        SRC_ALU0 = 3'd0,
        SRC_ALU1 = 3'd1,
        SRC_BRU  = 3'd2,
        SRC_LSU  = 3'd3,
        SRC_MDU  = 3'd4
    } wb_src_e;

    typedef logic [TAG_WIDTH-1:0] rob_tag_t;

    typedef struct packed {
        logic            is_valid;
        rob_tag_t        dest_tag;
        logic [XLEN-1:0] result;
        logic            exception;
    } writeback_packet_t;

    // Distance of a tag from the ROB head; the unsigned subtraction wraps
    // around the ROB, so a smaller value means an older instruction.
    function automatic rob_tag_t tag_age(rob_tag_t tag, rob_tag_t head);
        return tag - head;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback sources to CDB arbiter bus.
// Handshake: a packet moves into the source's holding buffer on a rising
// edge where src_valid[i] && src_ready[i] && src_packet[i].is_valid;
// src_ready never depends on src_valid. cdb_ports is a registered broadcast
// with no back-pressure: a port carries a result in any cycle its is_valid is 1.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic              [NUM_WB_SRC-1:0] src_valid;
    writeback_packet_t [NUM_WB_SRC-1:0] src_packet;
    logic              [NUM_WB_SRC-1:0] src_ready;
    writeback_packet_t [PIPE_WIDTH-1:0] cdb_ports;

    modport master (
        output src_valid,
        output src_packet,
        input  src_ready,
        input  cdb_ports
    );

    modport slave (
        input  src_valid,
        input  src_packet,
        output src_ready,
        output cdb_ports
    );

endinterface

// File: rtl/cdb_arbiter_age_select.sv
// Pick-two-oldest network. Each valid entry is ranked by how many other
// valid entries are older than it (ties go to the lower index); rank 0 is
// the oldest grant, rank 1 the second-oldest grant.
module cdb_arbiter_age_select
    import cdb_arbiter_pkg::*;
#(
    parameter int N = NUM_WB_SRC
) (
    input  logic [N-1:0]                valid,
    input  logic [N-1:0][TAG_WIDTH-1:0] age,
    output logic [N-1:0]                grant0,
    output logic [N-1:0]                grant1,
    output logic                        gnt_valid0,
    output logic                        gnt_valid1
);

    // Rank every valid entry against all others and emit one-hot grants
    always_comb begin
        logic [3:0] rank;
        grant0 = '0;
        grant1 = '0;
        rank   = '0;
        for (int i = 0; i < N; i++) begin
            rank = '0;
            for (int j = 0; j < N; j++) begin
                if (j != i && valid[j] &&
                    ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i)))) begin
                    rank = rank + 4'd1;
                end
            end
            grant0[i] = valid[i] && (rank == 4'd0);
            grant1[i] = valid[i] && (rank == 4'd1);
        end
        gnt_valid0 = |grant0;
        gnt_valid1 = |grant1;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding buffer per writeback source, oldest-first grant
// of up to two buffered results per cycle onto registered CDB ports,
// flush discard and a saturating contention counter.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  rob_tag_t      rob_head,
    cdb_arbiter_if.slave  bus,
    output logic [31:0]   conflict_cnt
);

    localparam int NUM_SRC = NUM_WB_SRC;
    localparam int NUM_CDB = PIPE_WIDTH;

    writeback_packet_t [NUM_SRC-1:0]                buf_q;
    logic              [NUM_SRC-1:0]                buf_valid;
    logic              [NUM_SRC-1:0][TAG_WIDTH-1:0] age;
    logic              [NUM_SRC-1:0]                grant0;
    logic              [NUM_SRC-1:0]                grant1;
    logic              [NUM_SRC-1:0]                grant;
    logic                                           gnt_valid0;
    logic                                           gnt_valid1;
    logic              [NUM_SRC-1:0]                ready;
    logic              [NUM_SRC-1:0]                accept;
    writeback_packet_t [NUM_CDB-1:0]                cdb_next;
    writeback_packet_t [NUM_CDB-1:0]                cdb_q;

    // Age of each buffered result relative to the current ROB head
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            age[i] = tag_age(buf_q[i].dest_tag, rob_head);
        end
    end

    cdb_arbiter_age_select #(.N(NUM_SRC)) u_age_select (
        .valid      (buf_valid),
        .age        (age),
        .grant0     (grant0),
        .grant1     (grant1),
        .gnt_valid0 (gnt_valid0),
        .gnt_valid1 (gnt_valid1)
    );

    assign grant = grant0 | grant1;

    // A buffer can take a new packet when empty or being drained this cycle;
    // a flush blocks all handoffs
    always_comb begin
        ready  = {NUM_SRC{!flush}} & (~buf_valid | grant);
        accept = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            accept[i] = bus.src_valid[i] && bus.src_packet[i].is_valid && ready[i];
        end
    end

    assign bus.src_ready = ready;

    // Route the oldest grant to port 0 and the second-oldest to port 1
    always_comb begin
        cdb_next = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant0[i]) begin
                cdb_next[0] = buf_q[i];
            end
            if (grant1[i]) begin
                cdb_next[1] = buf_q[i];
            end
        end
        cdb_next[0].is_valid = gnt_valid0;
        cdb_next[1].is_valid = gnt_valid1;
    end

    // Holding buffers: load on handshake, release on grant, drop on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= '0;
            buf_q     <= '0;
        end else if (flush) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (accept[i]) begin
                    buf_q[i]     <= bus.src_packet[i];
                    buf_valid[i] <= 1'b1;
                end else if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Registered CDB broadcast; a flush kills whatever was granted this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_q <= '0;
        end else if (flush) begin
            cdb_q <= '0;
        end else begin
            cdb_q <= cdb_next;
        end
    end

    assign bus.cdb_ports = cdb_q;

    // Count cycles with more pending results than CDB ports, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (($countones(buf_valid) > NUM_CDB) && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by a randomized stream,
// with a reference model that tracks buffer contents and predicts every CDB
// broadcast, src_ready and conflict_cnt.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int NS = NUM_WB_SRC;
    localparam int NC = PIPE_WIDTH;
    localparam int PW = $bits(writeback_packet_t);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    rob_tag_t    rob_head = '0;
    logic [31:0] conflict_cnt;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .rob_head     (rob_head),
        .bus          (bus.slave),
        .conflict_cnt (conflict_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int                checks = 0;
    int                errors = 0;
    logic [PW:0]       exp_q[$];
    logic [NS-1:0]     m_valid = '0;
    writeback_packet_t m_buf[NS];
    logic [31:0]       m_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Age as distance ahead of the ROB head, by modular arithmetic
    function automatic int age_of(int i);
        return (int'(m_buf[i].dest_tag) + ROB_ENTRIES - int'(rob_head)) % ROB_ENTRIES;
    endfunction

    // Two oldest pending model entries (-1 if none); ties keep lower index
    function automatic void model_pick(output int first, output int second);
        int a;
        first  = -1;
        second = -1;
        for (int i = 0; i < NS; i++) begin
            if (m_valid[i]) begin
                a = age_of(i);
                if (first < 0 || a < age_of(first)) begin
                    second = first;
                    first  = i;
                end else if (second < 0 || a < age_of(second)) begin
                    second = i;
                end
            end
        end
    endfunction

    function automatic logic [NS-1:0] model_ready();
        int f, s;
        logic [NS-1:0] r;
        model_pick(f, s);
        r = '0;
        for (int i = 0; i < NS; i++) begin
            r[i] = !flush && (!m_valid[i] || i == f || i == s);
        end
        return r;
    endfunction

    // Reference model: advances on every clock edge, resets asynchronously
    initial begin
        int f, s;
        logic [NS-1:0] rdy;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_valid = '0;
                m_cnt   = '0;
                exp_q.delete();
            end else begin
                model_pick(f, s);
                rdy = model_ready();
                if ($countones(m_valid) > NC && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (flush) begin
                    m_valid = '0;
                end else begin
                    if (f >= 0) begin
                        exp_q.push_back({1'b0, m_buf[f]});
                        m_valid[f] = 1'b0;
                    end
                    if (s >= 0) begin
                        exp_q.push_back({1'b1, m_buf[s]});
                        m_valid[s] = 1'b0;
                    end
                    for (int i = 0; i < NS; i++) begin
                        if (bus.src_valid[i] && bus.src_packet[i].is_valid && rdy[i]) begin
                            m_buf[i]   = bus.src_packet[i];
                            m_valid[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Monitor: on the falling edge compare ready, counter and every CDB port
    initial begin
        logic [PW:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("src_ready", 64'(bus.src_ready), 64'(model_ready()));
                check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
                for (int p = 0; p < NC; p++) begin
                    if (bus.cdb_ports[p].is_valid) begin
                        if (exp_q.size() == 0) begin
                            check("cdb_unexpected", 64'({1'(p), bus.cdb_ports[p]}), 64'(0));
                        end else begin
                            exp = exp_q.pop_front();
                            check("cdb_port", 64'({1'(p), bus.cdb_ports[p]}), 64'(exp));
                        end
                    end else begin
                        check("cdb_idle", 64'(bus.cdb_ports[p]), 64'(0));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input int tag);
        bus.src_valid[i]  = 1'b1;
        bus.src_packet[i] = '{is_valid: 1'b1, dest_tag: rob_tag_t'(tag),
                              result: 32'($urandom), exception: 1'($urandom_range(0, 1))};
    endtask

    task automatic clear_srcs();
        bus.src_valid  = '0;
        bus.src_packet = '0;
    endtask

    // Asynchronous reset between edges; outputs must clear at once
    task automatic do_reset();
        clear_srcs();
        flush = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_cdb0_valid", 64'(bus.cdb_ports[0].is_valid), 64'(0));
        check("rst_cdb1_valid", 64'(bus.cdb_ports[1].is_valid), 64'(0));
        check("rst_conflict_cnt", 64'(conflict_cnt), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_srcs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single result, uncontended: two cycles from source to CDB
        step();
        check("t1_ready", 64'(bus.src_ready), 64'(5'b11111));
        set_src(0, 3);
        step();
        clear_srcs();
        check("t1_no_bypass", 64'(bus.cdb_ports[0].is_valid), 64'(0));
        step();
        check("t1_port0_valid", 64'(bus.cdb_ports[0].is_valid), 64'(1));
        check("t1_port0_tag", 64'(bus.cdb_ports[0].dest_tag), 64'(3));
        check("t1_port1_valid", 64'(bus.cdb_ports[1].is_valid), 64'(0));

        // Age wraps around the ROB head
        do_reset();
        rob_head = 4'd14;
        set_src(0, 15);
        set_src(1, 1);
        set_src(2, 0);
        step();
        clear_srcs();
        step();
        check("t2_port0_tag", 64'(bus.cdb_ports[0].dest_tag), 64'(15));
        check("t2_port1_tag", 64'(bus.cdb_ports[1].dest_tag), 64'(0));
        check("t2_conflict", 64'(conflict_cnt), 64'(1));
        step();
        check("t2_late_tag", 64'(bus.cdb_ports[0].dest_tag), 64'(1));
        check("t2_late_p1", 64'(bus.cdb_ports[1].is_valid), 64'(0));

        // All five sources at once drain in age order over three cycles
        do_reset();
        rob_head = 4'd5;
        for (int i = 0; i < NS; i++) set_src(i, 5 + i);
        step();
        clear_srcs();
        step();
        check("t3_c1", 64'({bus.cdb_ports[0].dest_tag, bus.cdb_ports[1].dest_tag}), 64'(8'h56));
        step();
        check("t3_c2", 64'({bus.cdb_ports[0].dest_tag, bus.cdb_ports[1].dest_tag}), 64'(8'h78));
        step();
        check("t3_c3_tag", 64'(bus.cdb_ports[0].dest_tag), 64'(9));
        check("t3_c3_p1", 64'(bus.cdb_ports[1].is_valid), 64'(0));
        check("t3_ready", 64'(bus.src_ready), 64'(5'b11111));
        check("t3_conflict", 64'(conflict_cnt), 64'(2));

        // Reload of the LSU buffer in the same cycle it is granted
        do_reset();
        rob_head = 4'd0;
        set_src(SRC_LSU, 10);
        step();
        clear_srcs();
        check("t4_lsu_ready", 64'(bus.src_ready[SRC_LSU]), 64'(1));
        set_src(SRC_LSU, 12);
        step();
        clear_srcs();
        check("t4_first_tag", 64'(bus.cdb_ports[0].dest_tag), 64'(10));
        step();
        check("t4_second_valid", 64'(bus.cdb_ports[0].is_valid), 64'(1));
        check("t4_second_tag", 64'(bus.cdb_ports[0].dest_tag), 64'(12));

        // Flush with pending results and a source handing off
        do_reset();
        set_src(0, 1);
        set_src(1, 2);
        set_src(2, 3);
        step();
        clear_srcs();
        flush = 1'b1;
        set_src(4, 4);
        #1;
        check("t5_flush_ready", 64'(bus.src_ready), 64'(0));
        step();
        flush = 1'b0;
        clear_srcs();
        #1;
        check("t5_after_ready", 64'(bus.src_ready), 64'(5'b11111));
        for (int k = 0; k < 3; k++) begin
            check("t5_no_cdb", 64'({bus.cdb_ports[0].is_valid, bus.cdb_ports[1].is_valid}), 64'(0));
            step();
        end

        // Randomized stream with flushes, head movement and a mid-stream reset
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            clear_srcs();
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 1) == 1) set_src(i, $urandom_range(0, ROB_ENTRIES - 1));
            end
            if ($urandom_range(0, 19) == 0) rob_head = rob_tag_t'($urandom_range(0, ROB_ENTRIES - 1));
            flush = ($urandom_range(0, 39) == 0);
            if (c == 750) begin
                do_reset();
            end else begin
                step();
            end
        end
        clear_srcs();
        flush = 1'b0;
        repeat (6) step();
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
